dmem_wait_responder: RTL and testbench

- Data-memory responder on the memory end of the mips load/store interface (aluout word address, writedata, memwrite, readdata).
- Adds a read-enable and a stall handshake so the core can run against a multi-cycle memory.
- Holds the requester in stall for LATENCY cycles per access, then completes the read or commits the write.
- Emits a one-cycle write-commit strobe for bench logging.

---
 rtl/dmem_wait_responder_pkg.sv | 30 +++
 rtl/dmem_wait_responder_if.sv | 36 +++
 rtl/dmem_wait_array.sv | 29 ++
 rtl/dmem_wait_responder.sv | 133 +++++++++++++
 tb/tb_dmem_wait_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_wait_responder_pkg.sv
// Shared definitions for the data-memory wait responder slice.
//   - Default data width and word-address width, shared with mips/imem/dmem.
//   - FSM state encoding for the responder.
//   - ENABLE / DISABLE macros for single-bit control levels.
//   - wait_load(): counter preload for a given access latency.
`ifndef DMEM_WAIT_RESPONDER_PKG_SV
`define DMEM_WAIT_RESPONDER_PKG_SV

`define ENABLE  1'b1
`define DISABLE 1'b0

package dmem_wait_responder_pkg;

  localparam int DMEM_WIDTH    = 32;
  localparam int DMEM_ADDRBITS = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Value loaded into the wait counter when an access is accepted.
  function automatic logic [3:0] wait_load(input int latency);
    return (latency > 0) ? 4'(latency - 1) : 4'd0;
  endfunction

endpackage

`endif

// File: rtl/dmem_wait_responder_if.sv
// Load/store bus between the requester (mips core) and the data-memory
// responder.
//   a         word address of the request
//   re / we   read / write request (both high = write, rd gets old data)
//   wd        write data
//   rd        read data, non-zero only in a read's completion cycle
//   stall     requester holds a/re/we/wd stable while high
//   wr_strobe one-cycle pulse in the cycle a write commits
//   wr_addr   address of the committing write, valid with wr_strobe
interface dmem_wait_responder_if
  import dmem_wait_responder_pkg::*;
#(
  parameter int WIDTH    = DMEM_WIDTH,
  parameter int ADDRBITS = DMEM_ADDRBITS
);

  logic [ADDRBITS-1:0] a;
  logic                re;
  logic                we;
  logic [WIDTH-1:0]    wd;
  logic [WIDTH-1:0]    rd;
  logic                stall;
  logic                wr_strobe;
  logic [ADDRBITS-1:0] wr_addr;

  modport master (
    output a, re, we, wd,
    input  rd, stall, wr_strobe, wr_addr
  );

  modport slave (
    input  a, re, we, wd,
    output rd, stall, wr_strobe, wr_addr
  );

endinterface

// File: rtl/dmem_wait_array.sv
// Storage for the data-memory responder: 2^DEPTHBITS x WIDTH register array,
// synchronous write, asynchronous read.
//   clk  write clock
//   we   write enable, write happens at the rising edge
//   a    word index
//   wd   write data
//   rd   read data of word a (combinational, shows pre-write contents)
module dmem_wait_array #(
  parameter int WIDTH     = 32,
  parameter int DEPTHBITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTHBITS-1:0] a,
  input  logic [WIDTH-1:0]     wd,
  output logic [WIDTH-1:0]     rd
);

  logic [WIDTH-1:0] mem [2**DEPTHBITS];

  // NOTE: the storage has no reset; clearing a RAM needs a per-word write
  // path and would keep it from mapping onto memory primitives.
  always_ff @(posedge clk) begin
    if (we) mem[a] <= wd;
  end

  assign rd = mem[a];

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a fixed number of wait cycles per access.
// A request (re|we) is held off with stall for LATENCY cycles and completes
// in cycle LATENCY+1 counted from the first request cycle. LATENCY=0 gives a
// zero-wait memory: combinational read, write at the next edge.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   slave side of the load/store bus (see dmem_wait_responder_if)
module dmem_wait_responder
  import dmem_wait_responder_pkg::*;
#(
  parameter int WIDTH     = DMEM_WIDTH,
  parameter int ADDRBITS  = DMEM_ADDRBITS,
  parameter int DEPTHBITS = 6,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_wait_responder_if.slave   bus
);

  localparam logic [3:0] CNT_LOAD = wait_load(LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDRBITS-1:0] lat_a_q;
  logic                lat_re_q;
  logic                lat_we_q;
  logic [WIDTH-1:0]    lat_wd_q;

  logic                load;
  logic                use_lat;
  logic                commit;
  logic                rd_en;
  logic                stall;

  logic [ADDRBITS-1:0] arr_a;
  logic [WIDTH-1:0]    arr_wd;
  logic [WIDTH-1:0]    arr_rd;
  logic                arr_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      lat_a_q  <= '0;
      lat_re_q <= 1'b0;
      lat_we_q <= 1'b0;
      lat_wd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        lat_a_q  <= bus.a;
        lat_re_q <= bus.re;
        lat_we_q <= bus.we;
        lat_wd_q <= bus.wd;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    use_lat = 1'b0;
    commit  = 1'b0;
    rd_en   = 1'b0;
    stall   = `DISABLE;

    if (LATENCY == 0) begin
      // Zero-wait memory: serve the live request directly.
      commit = bus.we;
      rd_en  = bus.re;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.re || bus.we) begin
            load  = 1'b1;
            stall = `ENABLE;
            cnt_d = CNT_LOAD;
            // The request cycle is itself the first stall cycle, so WAIT
            // covers the remaining LATENCY-1; with LATENCY=1 there is none.
            state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          stall   = `ENABLE;
          use_lat = 1'b1;
          if (!(bus.re || bus.we)) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
            // Leave when the count reaches zero at this edge.
            if (cnt_q <= 4'd1) state_d = S_DONE;
          end
        end
        S_DONE: begin
          use_lat = 1'b1;
          commit  = lat_we_q;
          rd_en   = lat_re_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign arr_a  = use_lat ? lat_a_q  : bus.a;
  assign arr_wd = use_lat ? lat_wd_q : bus.wd;
  // A reset at the commit edge cancels the write and its strobe.
  assign arr_we = commit & ~rst;

  dmem_wait_array #(
    .WIDTH     (WIDTH),
    .DEPTHBITS (DEPTHBITS)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .a   (arr_a[DEPTHBITS-1:0]),
    .wd  (arr_wd),
    .rd  (arr_rd)
  );

  assign bus.stall     = stall;
  assign bus.rd        = rd_en  ? arr_rd : '0;
  assign bus.wr_strobe = arr_we;
  assign bus.wr_addr   = arr_we ? arr_a : '0;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder. Two instances run side by
// side: LATENCY=2 and LATENCY=0. A word-level shadow memory per instance
// gives the expected read data; the expected cycle-by-cycle handshake
// follows from the access timing rules (LATENCY stall cycles, completion
// in cycle LATENCY+1).
module tb_dmem_wait_responder;
  import dmem_wait_responder_pkg::*;

  localparam int W    = 32;
  localparam int AB   = 14;
  localparam int DB   = 6;
  localparam int LAT2 = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_wait_responder_if #(.WIDTH(W), .ADDRBITS(AB)) bus2 ();
  dmem_wait_responder_if #(.WIDTH(W), .ADDRBITS(AB)) bus0 ();

  dmem_wait_responder #(
    .WIDTH(W), .ADDRBITS(AB), .DEPTHBITS(DB), .LATENCY(LAT2)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  dmem_wait_responder #(
    .WIDTH(W), .ADDRBITS(AB), .DEPTHBITS(DB), .LATENCY(0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] model2 [2**DB];
  logic [W-1:0] model0 [2**DB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle2();
    bus2.re = 1'b0;
    bus2.we = 1'b0;
  endtask

  task automatic idle0();
    bus0.re = 1'b0;
    bus0.we = 1'b0;
  endtask

  // One idle cycle on the LATENCY=2 side: nothing may be presented.
  task automatic quiet2(input string tag);
    idle2();
    @(negedge clk);
    check({tag, " stall"}, bus2.stall, 0);
    check({tag, " strobe"}, bus2.wr_strobe, 0);
    check({tag, " rd"}, bus2.rd, 0);
    step();
  endtask

  // Full access on the LATENCY=2 instance. Called just after a rising edge.
  // wiggle scrambles a/wd during the wait to show the latched values win.
  task automatic l2_access(input logic r, input logic w, input logic [AB-1:0] addr,
                           input logic [W-1:0] data, input bit gap, input bit wiggle);
    logic [W-1:0] exp_rd;
    bus2.re = r;
    bus2.we = w;
    bus2.a  = addr;
    bus2.wd = data;
    exp_rd  = r ? model2[addr[DB-1:0]] : '0;
    for (int c = 1; c <= LAT2 + 1; c++) begin
      @(negedge clk);
      if (c <= LAT2) begin
        check("l2 stall", bus2.stall, 1);
        check("l2 strobe early", bus2.wr_strobe, 0);
        check("l2 rd early", bus2.rd, 0);
      end else begin
        check("l2 stall done", bus2.stall, 0);
        check("l2 rd", bus2.rd, exp_rd);
        check("l2 strobe", bus2.wr_strobe, {31'd0, w});
        check("l2 wr_addr", bus2.wr_addr, w ? {18'd0, addr} : 32'd0);
      end
      step();
      if (c == 1 && wiggle) begin
        bus2.a  = AB'($urandom);
        bus2.wd = $urandom;
      end
    end
    if (w) model2[addr[DB-1:0]] = data;
    if (gap) quiet2("l2 gap");
  endtask

  // Write withdrawn during the wait: no commit, no strobe.
  task automatic l2_abort(input logic [AB-1:0] addr, input logic [W-1:0] data);
    bus2.re = 1'b0;
    bus2.we = 1'b1;
    bus2.a  = addr;
    bus2.wd = data;
    @(negedge clk);
    check("abort stall req", bus2.stall, 1);
    step();
    idle2();
    @(negedge clk);
    check("abort stall wait", bus2.stall, 1);
    check("abort strobe wait", bus2.wr_strobe, 0);
    step();
    quiet2("abort after");
  endtask

  // Reset during WAIT (in_done=0) or DONE (in_done=1) of a write.
  task automatic l2_reset_mid(input logic [AB-1:0] addr, input logic [W-1:0] data,
                              input bit in_done);
    bus2.re = 1'b0;
    bus2.we = 1'b1;
    bus2.a  = addr;
    bus2.wd = data;
    @(negedge clk);
    check("rstmid stall req", bus2.stall, 1);
    step();
    if (in_done) step();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid strobe", bus2.wr_strobe, 0);
    step();
    rst = 1'b0;
    quiet2("rstmid after");
  endtask

  // Single-cycle access on the LATENCY=0 instance.
  task automatic l0_access(input logic r, input logic w, input logic [AB-1:0] addr,
                           input logic [W-1:0] data);
    bus0.re = r;
    bus0.we = w;
    bus0.a  = addr;
    bus0.wd = data;
    @(negedge clk);
    check("l0 stall", bus0.stall, 0);
    check("l0 rd", bus0.rd, r ? model0[addr[DB-1:0]] : 32'd0);
    check("l0 strobe", bus0.wr_strobe, {31'd0, w});
    check("l0 wr_addr", bus0.wr_addr, w ? {18'd0, addr} : 32'd0);
    step();
    if (w) model0[addr[DB-1:0]] = data;
  endtask

  initial begin
    rst = 1'b1;
    idle2();
    idle0();
    bus2.a = '0; bus2.wd = '0;
    bus0.a = '0; bus0.wd = '0;
    step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset stall2", bus2.stall, 0);
    check("reset rd2", bus2.rd, 0);
    check("reset strobe2", bus2.wr_strobe, 0);
    check("reset wr_addr2", bus2.wr_addr, 0);
    check("reset stall0", bus0.stall, 0);
    check("reset strobe0", bus0.wr_strobe, 0);
    step();

    // Give every word a known value.
    for (int i = 0; i < 2**DB; i++) l2_access(1'b0, 1'b1, AB'(i), $urandom, 1'b0, 1'b0);
    quiet2("fill end");
    for (int i = 0; i < 2**DB; i++) l0_access(1'b0, 1'b1, AB'(i), $urandom);
    idle0();

    // Write then read.
    l2_access(1'b0, 1'b1, 14'h0015, 32'h0000_0007, 1'b1, 1'b0);
    l2_access(1'b1, 1'b0, 14'h0015, 32'h0, 1'b1, 1'b0);

    // Back-to-back writes, then read both back.
    l2_access(1'b0, 1'b1, 14'h0001, 32'hAAAA_5555, 1'b0, 1'b0);
    l2_access(1'b0, 1'b1, 14'h0002, 32'h1234_5678, 1'b1, 1'b0);
    l2_access(1'b1, 1'b0, 14'h0001, 32'h0, 1'b0, 1'b0);
    l2_access(1'b1, 1'b0, 14'h0002, 32'h0, 1'b1, 1'b0);

    // Abort.
    l2_access(1'b0, 1'b1, 14'h0003, 32'h0, 1'b1, 1'b0);
    l2_abort(14'h0003, 32'hDEAD_BEEF);
    l2_access(1'b1, 1'b0, 14'h0003, 32'h0, 1'b1, 1'b0);

    // Reset in WAIT and in DONE.
    l2_reset_mid(14'h0005, 32'hDEAD_BEEF, 1'b0);
    l2_access(1'b1, 1'b0, 14'h0005, 32'h0, 1'b1, 1'b0);
    l2_reset_mid(14'h0006, 32'hCAFE_F00D, 1'b1);
    l2_access(1'b1, 1'b0, 14'h0006, 32'h0, 1'b1, 1'b0);

    // Read+write returns old data; address wraps; inputs scrambled in WAIT.
    l2_access(1'b1, 1'b1, 14'h0047, 32'h5A5A_A5A5, 1'b1, 1'b1);
    l2_access(1'b1, 1'b0, 14'h0007, 32'h0, 1'b1, 1'b1);

    // LATENCY=0 with wrap-around.
    l0_access(1'b0, 1'b1, 14'h0000, 32'h0000_00FF);
    l0_access(1'b1, 1'b0, 14'h0040, 32'h0);
    l0_access(1'b1, 1'b1, 14'h3FC0, 32'h0BAD_0BAD);
    l0_access(1'b1, 1'b0, 14'h0000, 32'h0);
    idle0();

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op == 0) l2_abort(AB'($urandom), $urandom);
      else l2_access(op[0] | (op >= 6), (op < 6) ? ~op[0] : op[1],
                     AB'($urandom), $urandom, 1'($urandom), 1'($urandom));
    end
    quiet2("rand end");

    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      l0_access(op != 1, op != 0, AB'($urandom), $urandom);
    end
    idle0();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
